// File: rtl/temp_sample_ctrl.sv
// -----------------------------------------------------------------------------
// temp_sample_ctrl
//
// Periodically requests a two-byte temperature read from the I2C read FSM.
// It converts the returned 12-bit two's-complement value (0.0625 C/LSB,
// left-justified in msb:lsb[7:4]) into a sign flag plus BCD hundreds, tens,
// ones and tenths digits. A request that gets no answer is abandoned after
// TIMEOUT cycles. Sampling is retried after the next PERIOD.
//
// Parameters
//   PERIOD   cycles spent in WAIT before each request (>= 2)
//   TIMEOUT  cycles allowed in BUSY for i_done (>= 2)
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_en           enables periodic sampling
//   o_start        one-cycle request pulse to the I2C read FSM
//   i_done         one-cycle result strobe from the I2C read FSM
//   i_msb          temperature high byte (integer part, two's complement)
//   i_lsb          temperature low byte ([7:4] fraction, [3:0] ignored)
//   o_sign         1 = negative temperature
//   o_hund/o_tens/o_ones/o_tenths  BCD magnitude digits
//   o_valid        one-cycle pulse, digits updated
//   o_timeout_err  last request got no i_done within TIMEOUT
// -----------------------------------------------------------------------------
module temp_sample_ctrl #(
    parameter int PERIOD  = 5_000_000,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    output logic       o_start,
    input  logic       i_done,
    input  logic [7:0] i_msb,
    input  logic [7:0] i_lsb,
    output logic       o_sign,
    output logic [3:0] o_hund,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic [3:0] o_tenths,
    output logic       o_valid,
    output logic       o_timeout_err
);

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_REQ  = 3'd1,
        S_BUSY = 3'd2,
        S_CONV = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    localparam logic [31:0] PER_LAST = 32'(PERIOD - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);
    // CONV runs one load cycle (index 0) followed by shift cycles 1..8.
    localparam logic [3:0]  CONV_LAST = 4'd8;

    // Magnitude of a 12-bit two's-complement value; -2048 maps to 0x800.
    function automatic logic [11:0] abs12(input logic [11:0] v);
        logic [11:0] r;
        if (v[11]) begin
            r = ~v + 12'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Sixteenths to tenths, truncating: (f * 10) >> 4.
    function automatic logic [3:0] frac_tenths(input logic [3:0] f);
        logic [7:0] p;
        p = {4'd0, f} * 8'd10;
        return p[7:4];
    endfunction

    // One double-dabble step: add 3 to each BCD digit >= 5, then shift left.
    // Layout is {hund, tens, ones, binary[7:0]}.
    function automatic logic [19:0] dd_step(input logic [19:0] x);
        logic [19:0] y;
        y = x;
        if (y[19:16] >= 4'd5) begin
            y[19:16] = y[19:16] + 4'd3;
        end else begin
            y[19:16] = y[19:16];
        end
        if (y[15:12] >= 4'd5) begin
            y[15:12] = y[15:12] + 4'd3;
        end else begin
            y[15:12] = y[15:12];
        end
        if (y[11:8] >= 4'd5) begin
            y[11:8] = y[11:8] + 4'd3;
        end else begin
            y[11:8] = y[11:8];
        end
        return {y[18:0], 1'b0};
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_per_cnt;
    logic [31:0] r_to_cnt;
    logic [11:0] r_v;
    logic [3:0]  r_cyc;
    logic [19:0] r_dd;
    logic        r_sign_c;
    logic [3:0]  r_tenths_c;

    logic        r_start;
    logic        r_valid;
    logic        r_timeout_err;
    logic        r_sign;
    logic [3:0]  r_hund;
    logic [3:0]  r_tens;
    logic [3:0]  r_ones;
    logic [3:0]  r_tenths;

    logic        w_per_clr;
    logic        w_per_inc;
    logic        w_to_clr;
    logic        w_to_inc;
    logic        w_capture;
    logic        w_to_fire;
    logic        w_out;
    logic [11:0] w_mag;
    logic        w_unused_lsb;

    // Low nibble of the low byte carries no temperature information.
    assign w_unused_lsb = ^i_lsb[3:0];
    assign w_mag        = abs12(r_v);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_next_state = r_state;
        w_per_clr    = 1'b0;
        w_per_inc    = 1'b0;
        w_to_clr     = 1'b0;
        w_to_inc     = 1'b0;
        w_capture    = 1'b0;
        w_to_fire    = 1'b0;
        w_out        = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (i_en) begin
                    if (r_per_cnt == PER_LAST) begin
                        w_next_state = S_REQ;
                        w_per_clr    = 1'b1;
                    end else begin
                        w_per_inc    = 1'b1;
                    end
                end else begin
                    w_per_clr = 1'b1;
                end
            end
            S_REQ: begin
                w_next_state = S_BUSY;
                w_to_clr     = 1'b1;
            end
            S_BUSY: begin
                // done takes priority over a coinciding timeout expiry
                if (i_done) begin
                    w_capture    = 1'b1;
                    w_next_state = S_CONV;
                end else if (r_to_cnt == TO_LAST) begin
                    w_to_fire    = 1'b1;
                    w_per_clr    = 1'b1;
                    w_next_state = S_WAIT;
                end else begin
                    w_to_inc     = 1'b1;
                end
            end
            S_CONV: begin
                if (r_cyc == CONV_LAST) begin
                    w_next_state = S_OUT;
                end else begin
                    w_next_state = S_CONV;
                end
            end
            S_OUT: begin
                w_out        = 1'b1;
                w_per_clr    = 1'b1;
                w_next_state = S_WAIT;
            end
            default: begin
                w_next_state = S_WAIT;
            end
        endcase
    end

    // Period and timeout counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_per_cnt <= 32'd0;
            r_to_cnt  <= 32'd0;
        end else begin
            if (w_per_clr) begin
                r_per_cnt <= 32'd0;
            end else if (w_per_inc) begin
                r_per_cnt <= r_per_cnt + 32'd1;
            end else begin
                r_per_cnt <= r_per_cnt;
            end
            if (w_to_clr) begin
                r_to_cnt <= 32'd0;
            end else if (w_to_inc) begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end else begin
                r_to_cnt <= r_to_cnt;
            end
        end
    end

    // Capture and conversion: load magnitude at cycle 0, then 8 dabble shifts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v        <= 12'd0;
            r_cyc      <= 4'd0;
            r_dd       <= 20'd0;
            r_sign_c   <= 1'b0;
            r_tenths_c <= 4'd0;
        end else if (w_capture) begin
            r_v        <= {i_msb, i_lsb[7:4]};
            r_cyc      <= 4'd0;
        end else if (r_state == S_CONV) begin
            r_cyc <= r_cyc + 4'd1;
            if (r_cyc == 4'd0) begin
                r_sign_c   <= r_v[11];
                r_tenths_c <= frac_tenths(w_mag[3:0]);
                r_dd       <= {12'd0, w_mag[11:4]};
            end else begin
                r_dd <= dd_step(r_dd);
            end
        end else begin
            r_cyc <= r_cyc;
        end
    end

    // Registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_start       <= 1'b0;
            r_valid       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_sign        <= 1'b0;
            r_hund        <= 4'd0;
            r_tens        <= 4'd0;
            r_ones        <= 4'd0;
            r_tenths      <= 4'd0;
        end else begin
            r_start <= (w_next_state == S_REQ);
            r_valid <= w_out;
            if (w_to_fire) begin
                r_timeout_err <= 1'b1;
            end else if (w_out) begin
                r_timeout_err <= 1'b0;
            end else begin
                r_timeout_err <= r_timeout_err;
            end
            if (w_out) begin
                r_sign   <= r_sign_c;
                r_hund   <= r_dd[19:16];
                r_tens   <= r_dd[15:12];
                r_ones   <= r_dd[11:8];
                r_tenths <= r_tenths_c;
            end else begin
                r_sign   <= r_sign;
                r_hund   <= r_hund;
                r_tens   <= r_tens;
                r_ones   <= r_ones;
                r_tenths <= r_tenths;
            end
        end
    end

    assign o_start       = r_start;
    assign o_valid       = r_valid;
    assign o_timeout_err = r_timeout_err;
    assign o_sign        = r_sign;
    assign o_hund        = r_hund;
    assign o_tens        = r_tens;
    assign o_ones        = r_ones;
    assign o_tenths      = r_tenths;

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// -----------------------------------------------------------------------------
// tb_temp_sample_ctrl
//
// Directed bench for temp_sample_ctrl with PERIOD=16 and TIMEOUT=32.
// A table of {msb, lsb, expected sign/digits} records is answered in turn.
// Hand-written sequences cover first-request timing, timeout and retry,
// done/timeout collision, reset mid-conversion, en drop and stray done.
// -----------------------------------------------------------------------------
module tb_temp_sample_ctrl;

    localparam int PERIOD  = 16;
    localparam int TIMEOUT = 32;

    logic       clk;
    logic       rst;
    logic       en;
    logic       start;
    logic       done;
    logic [7:0] msb;
    logic [7:0] lsb;
    logic       sign;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] tenths;
    logic       valid;
    logic       terr;

    temp_sample_ctrl #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .o_start       (start),
        .i_done        (done),
        .i_msb         (msb),
        .i_lsb         (lsb),
        .o_sign        (sign),
        .o_hund        (hund),
        .o_tens        (tens),
        .o_ones        (ones),
        .o_tenths      (tenths),
        .o_valid       (valid),
        .o_timeout_err (terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  msb;
        logic [7:0]  lsb;
        logic [16:0] exp;   // {sign, hund, tens, ones, tenths}
    } vec_t;

    vec_t        tbl[9];
    int          total;
    int          bad;
    logic [16:0] prev;      // digits expected to be held on the outputs
    logic        exp_err;   // timeout_err expected while a request is pending

    function automatic logic [16:0] digits();
        return {sign, hund, tens, ones, tenths};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Waits for a start pulse, expecting it on negedge number exp_n.
    task automatic wait_start(input int exp_n);
        int n;
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (start === 1'b1) seen = 1'b1;
        end
        chk("start_seen", {31'd0, seen}, 32'd1);
        chk("start_delay", n, exp_n);
    endtask

    // Called at the negedge where start is high. Answers after dly BUSY cycles
    // and checks the valid pulse and digits around the 10th edge after done.
    task automatic respond(input vec_t v, input int dly);
        @(negedge clk);
        chk("start_width", {31'd0, start}, 32'd0);
        for (int d = 0; d < dly; d++) @(negedge clk);
        done = 1'b1;
        msb  = v.msb;
        lsb  = v.lsb;
        @(negedge clk);
        done = 1'b0;
        msb  = 8'hAA;
        lsb  = 8'h55;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk("valid_timing", {31'd0, valid}, {31'd0, (k == 10)});
            chk("no_start_busy", {31'd0, start}, 32'd0);
            if (k == 9) begin
                chk("digits_held", {15'd0, digits()}, {15'd0, prev});
                chk("err_before_out", {31'd0, terr}, {31'd0, exp_err});
            end
            if (k == 10) begin
                chk("digits", {15'd0, digits()}, {15'd0, v.exp});
                chk("err_after_out", {31'd0, terr}, 32'd0);
            end
        end
        prev    = v.exp;
        exp_err = 1'b0;
    endtask

    initial begin
        vec_t w;
        total   = 0;
        bad     = 0;
        prev    = 17'd0;
        exp_err = 1'b0;
        tbl[0] = '{8'h19, 8'h80, {1'b0, 4'd0, 4'd2, 4'd5, 4'd5}};  //  25.5
        tbl[1] = '{8'hE7, 8'h00, {1'b1, 4'd0, 4'd2, 4'd5, 4'd0}};  // -25.0
        tbl[2] = '{8'h80, 8'h00, {1'b1, 4'd1, 4'd2, 4'd8, 4'd0}};  // -128.0
        tbl[3] = '{8'h7F, 8'hF0, {1'b0, 4'd1, 4'd2, 4'd7, 4'd9}};  // 127.9375
        tbl[4] = '{8'h00, 8'h10, {1'b0, 4'd0, 4'd0, 4'd0, 4'd0}};  // 0.0625
        tbl[5] = '{8'hFF, 8'h80, {1'b1, 4'd0, 4'd0, 4'd0, 4'd5}};  // -0.5
        tbl[6] = '{8'h63, 8'h2F, {1'b0, 4'd0, 4'd9, 4'd9, 4'd1}};  // 99.125
        tbl[7] = '{8'hF6, 8'h70, {1'b1, 4'd0, 4'd0, 4'd9, 4'd5}};  // -9.5625
        tbl[8] = '{8'h64, 8'h00, {1'b0, 4'd1, 4'd0, 4'd0, 4'd0}};  // 100.0

        rst  = 1'b1;
        en   = 1'b0;
        done = 1'b0;
        msb  = 8'h00;
        lsb  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_state", {11'd0, start, valid, terr, digits()}, 32'd0);

        // First request: start high exactly on the 16th edge after release.
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            chk("first_start", {31'd0, start}, {31'd0, (k == PERIOD)});
            chk("first_idle", {30'd0, valid, terr}, 32'd0);
        end
        respond(tbl[0], 0);

        for (int i = 1; i < 9; i++) begin
            wait_start(PERIOD - 1);
            respond(tbl[i], 0);
        end

        // Withhold done: error after TIMEOUT edges, retry one PERIOD later.
        wait_start(PERIOD - 1);
        @(negedge clk);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            chk("timeout_rise", {31'd0, terr}, {31'd0, (k == TIMEOUT)});
        end
        chk("digits_hold_timeout", {15'd0, digits()}, {15'd0, prev});
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            chk("retry_start", {31'd0, start}, {31'd0, (k == PERIOD)});
            chk("err_sticky", {31'd0, terr}, 32'd1);
        end
        exp_err = 1'b1;
        w = '{8'h00, 8'h80, {1'b0, 4'd0, 4'd0, 4'd0, 4'd5}};
        respond(w, 0);

        // done on the very cycle the timeout would expire: done wins.
        wait_start(PERIOD - 1);
        respond(tbl[3], TIMEOUT - 1);

        // Reset while converting: outputs cleared, no valid for that sample.
        wait_start(PERIOD - 1);
        @(negedge clk);
        done = 1'b1;
        msb  = 8'h19;
        lsb  = 8'h80;
        @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_conv", {11'd0, start, valid, terr, digits()}, 32'd0);
        rst  = 1'b0;
        prev = 17'd0;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            chk("no_valid_after_reset", {31'd0, valid}, 32'd0);
            chk("restart_start", {31'd0, start}, {31'd0, (k == PERIOD)});
        end
        respond(tbl[1], 0);

        // en dropped during the transaction: it completes, then no new start.
        wait_start(PERIOD - 1);
        en = 1'b0;
        respond(tbl[2], 3);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            chk("no_start_en_low", {31'd0, start}, 32'd0);
        end

        // Stray done in WAIT is ignored.
        done = 1'b1;
        msb  = 8'h7F;
        lsb  = 8'hF0;
        @(negedge clk);
        done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("stray_done_valid", {31'd0, valid}, 32'd0);
        end
        chk("stray_done_digits", {15'd0, digits()}, {15'd0, prev});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
